// File: rtl/calc_resp_sched_if.sv
// Lane-result and response-mux signal bundle for calc_resp_sched.
// master: the ALU-lane / mux side. slave: the scheduler itself.
interface calc_resp_sched_if;
   logic        add_vld;
   logic [0:1]  add_resp;
   logic [0:31] add_data;
   logic        shf_vld;
   logic [0:1]  shf_resp;
   logic [0:31] shf_data;
   logic        add_full;
   logic        shf_full;
   logic [0:31] req_data1;
   logic [0:1]  req_resp1;
   logic [0:31] req_data2;
   logic [0:1]  req_resp2;

   modport master (
      output add_vld, add_resp, add_data, shf_vld, shf_resp, shf_data,
      input  add_full, shf_full, req_data1, req_resp1, req_data2, req_resp2
   );

   modport slave (
      input  add_vld, add_resp, add_data, shf_vld, shf_resp, shf_data,
      output add_full, shf_full, req_data1, req_resp1, req_data2, req_resp2
   );
endinterface

// File: rtl/calc_resp_sched.sv
// calc_resp_sched: buffers adder and shifter results in per-lane FIFOs and
// issues at most one registered response per cycle with round-robin
// arbitration. Lane 0 is the adder, lane 1 the shifter.
// Optional macro RESP_SCHED_STATS_EN adds the drop_cnt/issue_cnt counters.
module calc_resp_sched #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
`ifdef RESP_SCHED_STATS_EN
   output logic [0:7]  drop_cnt,
   output logic [0:15] issue_cnt,
`endif
   input  logic        c_clk,
   input  logic        reset,
   calc_resp_sched_if.slave bus
);

   typedef enum logic {GRANT_ADD = 1'b0, GRANT_SHF = 1'b1} grant_e;

   localparam int LANES = 2;

   logic [LANES-1:0] lane_vld;
   logic [LANES-1:0] lane_push;
   logic [LANES-1:0] lane_pop;
   logic [LANES-1:0] lane_ne;
   logic [LANES-1:0] lane_full;
   logic [LANES-1:0] lane_drop;
   logic [0:1]       lane_resp [LANES];
   logic [0:31]      lane_data [LANES];
   logic [0:33]      lane_head [LANES];

   grant_e      last_grant_q, last_grant_d;
   logic [0:1]  req_resp1_q, req_resp1_d;
   logic [0:31] req_data1_q, req_data1_d;
   logic [0:1]  req_resp2_q, req_resp2_d;
   logic [0:31] req_data2_q, req_data2_d;

   assign lane_vld     = {bus.shf_vld, bus.add_vld};
   assign lane_resp[0] = bus.add_resp;
   assign lane_resp[1] = bus.shf_resp;
   assign lane_data[0] = bus.add_data;
   assign lane_data[1] = bus.shf_data;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [0:33]   mem_q [DEPTH];
         logic [AW-1:0] wr_ptr_q, wr_ptr_d;
         logic [AW-1:0] rd_ptr_q, rd_ptr_d;
         logic [AW:0]   cnt_q, cnt_d;
         logic          full_q, full_d;

         // Full is judged on the registered (pre-edge) count, so a push
         // into a full FIFO is dropped even when that FIFO pops this cycle.
         assign lane_push[gi] = lane_vld[gi] && (lane_resp[gi] != 2'b00) && !full_q;
         assign lane_drop[gi] = lane_vld[gi] && (lane_resp[gi] != 2'b00) && full_q;
         assign lane_ne[gi]   = (cnt_q != '0);
         assign lane_full[gi] = full_q;
         assign lane_head[gi] = mem_q[rd_ptr_q];

         // Pointer/count bookkeeping; simultaneous push and pop leave count alone.
         always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (lane_push[gi]) wr_ptr_d = wr_ptr_q + AW'(1);
            if (lane_pop[gi])  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({lane_push[gi], lane_pop[gi]})
               2'b10:   cnt_d = cnt_q + (AW+1)'(1);
               2'b01:   cnt_d = cnt_q - (AW+1)'(1);
               default: cnt_d = cnt_q;
            endcase
            full_d = (cnt_d == (AW+1)'(DEPTH));
         end

         // FIFO control state register.
         always_ff @(posedge c_clk) begin
            if (reset) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
               full_q   <= 1'b0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               cnt_q    <= cnt_d;
               full_q   <= full_d;
            end
         end

         // Entry storage; contents need no reset since the count gates reads.
         always_ff @(posedge c_clk) begin
            if (!reset && lane_push[gi]) begin
               mem_q[wr_ptr_q] <= {lane_resp[gi], lane_data[gi]};
            end
         end
      end
   endgenerate

   // Round-robin pick between non-empty lanes and next response outputs.
   always_comb begin
      lane_pop     = '0;
      last_grant_d = last_grant_q;
      req_resp1_d  = '0;
      req_data1_d  = '0;
      req_resp2_d  = '0;
      req_data2_d  = '0;
      if (lane_ne[0] && (!lane_ne[1] || last_grant_q == GRANT_SHF)) begin
         lane_pop[0]  = 1'b1;
         last_grant_d = GRANT_ADD;
         req_resp1_d  = lane_head[0][0:1];
         req_data1_d  = lane_head[0][2:33];
      end else if (lane_ne[1]) begin
         lane_pop[1]  = 1'b1;
         last_grant_d = GRANT_SHF;
         req_resp2_d  = lane_head[1][0:1];
         req_data2_d  = lane_head[1][2:33];
      end
   end

   // Output and grant registers; reset leaves the adder first in line.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         last_grant_q <= GRANT_SHF;
         req_resp1_q  <= '0;
         req_data1_q  <= '0;
         req_resp2_q  <= '0;
         req_data2_q  <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         req_resp1_q  <= req_resp1_d;
         req_data1_q  <= req_data1_d;
         req_resp2_q  <= req_resp2_d;
         req_data2_q  <= req_data2_d;
      end
   end

   assign bus.req_resp1 = req_resp1_q;
   assign bus.req_data1 = req_data1_q;
   assign bus.req_resp2 = req_resp2_q;
   assign bus.req_data2 = req_data2_q;
   assign bus.add_full  = lane_full[0];
   assign bus.shf_full  = lane_full[1];

`ifdef RESP_SCHED_STATS_EN
   logic [0:7]  drop_cnt_q, drop_cnt_d;
   logic [0:15] issue_cnt_q, issue_cnt_d;
   logic [8:0]  drop_sum;

   // Saturating drop counter (both lanes may drop together) and wrapping issue counter.
   always_comb begin
      drop_sum    = {1'b0, drop_cnt_q} + 9'(lane_drop[0]) + 9'(lane_drop[1]);
      drop_cnt_d  = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
      issue_cnt_d = issue_cnt_q + 16'(|lane_pop);
   end

   // Statistics registers.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         drop_cnt_q  <= '0;
         issue_cnt_q <= '0;
      end else begin
         drop_cnt_q  <= drop_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign drop_cnt  = drop_cnt_q;
   assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_calc_resp_sched.sv
// Directed testbench for calc_resp_sched: reset/idle, single push latency,
// simultaneous push ordering, dual-lane burst with overflow drops, reset
// flush and resp=00 filtering.
module tb_calc_resp_sched;

   logic c_clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 c_clk = ~c_clk;

   calc_resp_sched_if bus ();

`ifdef RESP_SCHED_STATS_EN
   logic [0:7]  drop_cnt;
   logic [0:15] issue_cnt;
`endif

   calc_resp_sched dut (
`ifdef RESP_SCHED_STATS_EN
      .drop_cnt  (drop_cnt),
      .issue_cnt (issue_cnt),
`endif
      .c_clk     (c_clk),
      .reset     (reset),
      .bus       (bus.slave)
   );

   // Stimulus values for the burst test (inputs only, not a model of the DUT).
   function automatic logic [0:31] a_data(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction
   function automatic logic [0:1] a_resp(input int i);
      return (i == 3) ? 2'b11 : 2'b01;
   endfunction
   function automatic logic [0:31] s_data(input int i);
      return 32'h5000_0000 + 32'(i);
   endfunction
   function automatic logic [0:1] s_resp(input int i);
      return (i == 2) ? 2'b11 : 2'b10;
   endfunction

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [0:1] ar, input logic [0:31] ad,
                        input logic sv, input logic [0:1] sr, input logic [0:31] sd);
      bus.add_vld  = av;
      bus.add_resp = ar;
      bus.add_data = ad;
      bus.shf_vld  = sv;
      bus.shf_resp = sr;
      bus.shf_data = sd;
   endtask

   task automatic chk_out(input string tag, input logic [0:1] r1, input logic [0:31] d1,
                          input logic [0:1] r2, input logic [0:31] d2);
      chk(tag, {bus.req_resp1, bus.req_data1, bus.req_resp2, bus.req_data2},
          {r1, d1, r2, d2});
   endtask

   task automatic do_reset();
      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Burst expectations per edge: lane (0 none, 1 add, 2 shf), entry index,
   // {add_full, shf_full}.
   int         exp_lane [16];
   int         exp_idx  [16];
   logic [1:0] exp_full [16];

   initial begin
      exp_lane = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 0};
      exp_idx  = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 7, 0};
      exp_full = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01,
                   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Reset then idle.
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out("idle_out", 2'b00, 32'd0, 2'b00, 32'd0);
         chk("idle_full", 68'({bus.add_full, bus.shf_full}), 68'd0);
      end
`ifdef RESP_SCHED_STATS_EN
      chk("reset_stats", 68'({drop_cnt, issue_cnt}), 68'd0);
`endif

      // Single adder push: visible exactly one cycle, one edge after the push.
      drive(1, 2'b01, 32'd4096, 0, 2'b00, 32'd0);
      step();
      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      chk_out("single_push_edge", 2'b00, 32'd0, 2'b00, 32'd0);
      step();
      chk_out("single_issue", 2'b01, 32'd4096, 2'b00, 32'd0);
      step();
      chk_out("single_after", 2'b00, 32'd0, 2'b00, 32'd0);

      // Simultaneous push after reset: adder first, shifter next.
      do_reset();
      drive(1, 2'b01, 32'd4096, 1, 2'b01, 32'd1234);
      step();
      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      chk_out("dual_push_edge", 2'b00, 32'd0, 2'b00, 32'd0);
      step();
      chk_out("dual_add_first", 2'b01, 32'd4096, 2'b00, 32'd0);
      step();
      chk_out("dual_shf_next", 2'b00, 32'd0, 2'b01, 32'd1234);
      step();
      chk_out("dual_after", 2'b00, 32'd0, 2'b00, 32'd0);

      // Continuous pushes on both lanes for 8 edges: strict alternation,
      // both FIFOs reach full and each lane drops one entry.
      do_reset();
      for (int e = 0; e < 16; e++) begin
         if (e < 8) drive(1, a_resp(e), a_data(e), 1, s_resp(e), s_data(e));
         else       drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
         step();
         case (exp_lane[e])
            1:       chk_out("burst_out", a_resp(exp_idx[e]), a_data(exp_idx[e]), 2'b00, 32'd0);
            2:       chk_out("burst_out", 2'b00, 32'd0, s_resp(exp_idx[e]), s_data(exp_idx[e]));
            default: chk_out("burst_out", 2'b00, 32'd0, 2'b00, 32'd0);
         endcase
         chk("burst_full", 68'({bus.add_full, bus.shf_full}), 68'(exp_full[e]));
      end
`ifdef RESP_SCHED_STATS_EN
      chk("burst_drop_cnt", 68'(drop_cnt), 68'd2);
      chk("burst_issue_cnt", 68'(issue_cnt), 68'd14);
`endif

      // Fill both lanes, then reset with pushes still asserted.
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'b01, 32'h1111_0000 + 32'(i), 1, 2'b10, 32'h2222_0000 + 32'(i));
         step();
      end
      reset = 1'b1;
      step();
      chk_out("reset_flush_out", 2'b00, 32'd0, 2'b00, 32'd0);
      chk("reset_flush_full", 68'({bus.add_full, bus.shf_full}), 68'd0);
`ifdef RESP_SCHED_STATS_EN
      chk("reset_flush_stats", 68'({drop_cnt, issue_cnt}), 68'd0);
`endif
      reset = 1'b0;
      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("no_stale", 2'b00, 32'd0, 2'b00, 32'd0);
      end

      // vld with resp=00 is ignored on both lanes.
      drive(1, 2'b00, 32'hDEAD_BEEF, 1, 2'b00, 32'hCAFE_F00D);
      step();
      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("resp00_ignored", 2'b00, 32'd0, 2'b00, 32'd0);
      end

      // A genuine push still works after that.
      drive(0, 2'b00, 32'd0, 1, 2'b10, 32'd77);
      step();
      drive(0, 2'b00, 32'd0, 0, 2'b00, 32'd0);
      step();
      chk_out("shf_only_issue", 2'b00, 32'd0, 2'b10, 32'd77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
